// File: rtl/motion_pkg.sv
// Shared motion-arbitration definitions: FSM state encoding, requester
// indices, default speed width and a fixed-priority one-hot picker.
package motion_pkg;

    localparam int DEF_SPEED_W = 8;

    localparam int REQ_ESC = 0;
    localparam int REQ_RND = 1;
    localparam int REQ_SPI = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BRAKE = 2'd2
    } arb_state_e;

    // Isolates the lowest set bit; bit 0 is the highest priority.
    function automatic logic [2:0] prio_pick(input logic [2:0] req);
        prio_pick = req & (~req + 3'd1);
    endfunction

endpackage

// File: rtl/slew_limiter.sv
// Single signed speed channel: command walks toward target by at most
// SLEW_STEP per cycle. Ports: clk, rst_n, target in, cmd out, at_zero out.
// Only built when SLEW_LIMIT_EN is defined.
`ifdef SLEW_LIMIT_EN
module slew_limiter #(
    parameter int SPEED_W   = 8,
    parameter int SLEW_STEP = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic signed [SPEED_W-1:0] target,
    output logic signed [SPEED_W-1:0] cmd,
    output logic                      at_zero
);

    localparam logic signed [SPEED_W:0]   STEP_X = (SPEED_W+1)'(SLEW_STEP);
    localparam logic signed [SPEED_W-1:0] STEP_N = SPEED_W'(SLEW_STEP);

    logic signed [SPEED_W-1:0] cmd_q;
    logic signed [SPEED_W-1:0] cmd_d;
    logic signed [SPEED_W:0]   diff;

    always_comb begin
        // One extra bit so the distance between any two speeds fits.
        diff = {target[SPEED_W-1], target} - {cmd_q[SPEED_W-1], cmd_q};
        if (diff > STEP_X) begin
            cmd_d = cmd_q + STEP_N;
        end else if (diff < -STEP_X) begin
            cmd_d = cmd_q - STEP_N;
        end else begin
            cmd_d = target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q <= '0;
        end else begin
            cmd_q <= cmd_d;
        end
    end

    assign cmd     = cmd_q;
    assign at_zero = (cmd_q == '0);

endmodule
`endif

// File: rtl/wheel_cmd_arbiter.sv
// Fixed-priority owner of the two wheel speed commands (esc > rnd > spi)
// with a zero-speed brake interval on every ownership change.
// Ports: clk, rst (async active-low), {esc,rnd,spi}_req, per-source
// signed _l/_r speeds; outputs grant (one-hot), left_cmd, right_cmd,
// motor_en (RUN), braking (BRAKE). Option: SLEW_LIMIT_EN.
module wheel_cmd_arbiter
    import motion_pkg::*;
#(
    parameter int SPEED_W      = DEF_SPEED_W,
    parameter int BRAKE_CYCLES = 16,
    parameter int SLEW_STEP    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      esc_req,
    input  logic                      rnd_req,
    input  logic                      spi_req,
    input  logic signed [SPEED_W-1:0] esc_l,
    input  logic signed [SPEED_W-1:0] esc_r,
    input  logic signed [SPEED_W-1:0] rnd_l,
    input  logic signed [SPEED_W-1:0] rnd_r,
    input  logic signed [SPEED_W-1:0] spi_l,
    input  logic signed [SPEED_W-1:0] spi_r,
    output logic [2:0]                grant,
    output logic signed [SPEED_W-1:0] left_cmd,
    output logic signed [SPEED_W-1:0] right_cmd,
    output logic                      motor_en,
    output logic                      braking
);

    if (BRAKE_CYCLES < 1 || BRAKE_CYCLES > 255 || SLEW_STEP < 1) begin : g_param_check
        $error("wheel_cmd_arbiter: parameter out of range");
    end

    arb_state_e state_q, state_d;
    logic [2:0] grant_q, grant_d;
    logic [7:0] cnt_q, cnt_d;
    logic       motor_en_q, motor_en_d;
    logic       braking_q, braking_d;

    logic [2:0] reqs;
    logic       higher;
    logic       owner_gone;
    logic       cmds_zero;

    logic signed [SPEED_W-1:0] tgt_l, tgt_r;

    assign reqs = {spi_req, rnd_req, esc_req};
    // grant_q - 1 masks exactly the bits above the owner in priority.
    assign higher     = |(reqs & (grant_q - 3'd1));
    assign owner_gone = ~|(reqs & grant_q);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (|reqs) begin
                    state_d = RUN;
                    grant_d = prio_pick(reqs);
                end
            end
            RUN: begin
                if (owner_gone || higher) begin
                    state_d = BRAKE;
                    grant_d = '0;
                    cnt_d   = 8'(BRAKE_CYCLES);
                end
            end
            BRAKE: begin
                // Count only once both wheels are actually stopped.
                if (cmds_zero) begin
                    if (cnt_q <= 8'd1) begin
                        cnt_d = '0;
                        if (|reqs) begin
                            state_d = RUN;
                            grant_d = prio_pick(reqs);
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
        motor_en_d = (state_d == RUN);
        braking_d  = (state_d == BRAKE);
    end

    always_comb begin
        tgt_l = '0;
        tgt_r = '0;
        unique case (1'b1)
            grant_d[REQ_ESC]: begin
                tgt_l = esc_l;
                tgt_r = esc_r;
            end
            grant_d[REQ_RND]: begin
                tgt_l = rnd_l;
                tgt_r = rnd_r;
            end
            grant_d[REQ_SPI]: begin
                tgt_l = spi_l;
                tgt_r = spi_r;
            end
            default: ;
        endcase
    end

`ifdef SLEW_LIMIT_EN
    logic l_zero, r_zero;

    slew_limiter #(
        .SPEED_W   (SPEED_W),
        .SLEW_STEP (SLEW_STEP)
    ) u_slew_l (
        .clk     (clk),
        .rst_n   (rst),
        .target  (tgt_l),
        .cmd     (left_cmd),
        .at_zero (l_zero)
    );

    slew_limiter #(
        .SPEED_W   (SPEED_W),
        .SLEW_STEP (SLEW_STEP)
    ) u_slew_r (
        .clk     (clk),
        .rst_n   (rst),
        .target  (tgt_r),
        .cmd     (right_cmd),
        .at_zero (r_zero)
    );

    assign cmds_zero = l_zero & r_zero;
`else
    logic signed [SPEED_W-1:0] left_q, right_q;

    assign cmds_zero = 1'b1;
    assign left_cmd  = left_q;
    assign right_cmd = right_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            cnt_q      <= '0;
            motor_en_q <= 1'b0;
            braking_q  <= 1'b0;
`ifndef SLEW_LIMIT_EN
            left_q     <= '0;
            right_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            cnt_q      <= cnt_d;
            motor_en_q <= motor_en_d;
            braking_q  <= braking_d;
`ifndef SLEW_LIMIT_EN
            left_q     <= tgt_l;
            right_q    <= tgt_r;
`endif
        end
    end

    assign grant    = grant_q;
    assign motor_en = motor_en_q;
    assign braking  = braking_q;

endmodule

// File: tb/tb_wheel_cmd_arbiter.sv
// Bench for wheel_cmd_arbiter: vector table of directed sequences, async
// reset mid-brake, then randomized traffic against a behavioural model.
module tb_wheel_cmd_arbiter;

    localparam int W    = 8;
    localparam int BRK  = 16;
    localparam int STEP = 4;

    logic clk = 1'b0;
    logic rst;
    logic esc_req, rnd_req, spi_req;
    logic signed [W-1:0] esc_l, esc_r, rnd_l, rnd_r, spi_l, spi_r;
    logic [2:0] grant;
    logic signed [W-1:0] left_cmd, right_cmd;
    logic motor_en, braking;

    always #5 clk = ~clk;

    wheel_cmd_arbiter #(
        .SPEED_W      (W),
        .BRAKE_CYCLES (BRK),
        .SLEW_STEP    (STEP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .esc_req   (esc_req),
        .rnd_req   (rnd_req),
        .spi_req   (spi_req),
        .esc_l     (esc_l),
        .esc_r     (esc_r),
        .rnd_l     (rnd_l),
        .rnd_r     (rnd_r),
        .spi_l     (spi_l),
        .spi_r     (spi_r),
        .grant     (grant),
        .left_cmd  (left_cmd),
        .right_cmd (right_cmd),
        .motor_en  (motor_en),
        .braking   (braking)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string nm, input logic [2:0] eg,
                         input int el, input int er,
                         input logic eme, input logic ebr);
        n_total++;
        if (grant === eg && left_cmd === W'(el) && right_cmd === W'(er)
            && motor_en === eme && braking === ebr) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got grant=%b l=%0d r=%0d en=%b brk=%b want grant=%b l=%0d r=%0d en=%b brk=%b",
                     nm, grant, left_cmd, right_cmd, motor_en, braking,
                     eg, el, er, eme, ebr);
        end
    endtask

    typedef struct {
        int         reps;
        logic [2:0] req;
        int         sl;
        int         sr;
        logic [2:0] g;
        int         l;
        int         r;
        logic       me;
        logic       br;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input int reps, input logic [2:0] req,
                       input int sl, input int sr, input logic [2:0] g,
                       input int l, input int r,
                       input logic me, input logic br);
        vec_t v;
        v.reps = reps; v.req = req; v.sl = sl; v.sr = sr;
        v.g = g; v.l = l; v.r = r; v.me = me; v.br = br;
        tbl.push_back(v);
    endtask

    // Behavioural model: who owns the wheels, how much brake time is
    // left, and where each commanded speed currently sits.
    int m_mode;   // 0 idle, 1 run, 2 brake
    int m_own;
    int m_rem;
    int m_l, m_r;

    function automatic int first_req(input logic [2:0] rq);
        for (int i = 0; i < 3; i++) if (rq[i]) return i;
        return -1;
    endfunction

    function automatic int move(input int cur, input int tgt);
`ifdef SLEW_LIMIT_EN
        if (tgt - cur > STEP) return cur + STEP;
        if (cur - tgt > STEP) return cur - STEP;
        return tgt;
`else
        return tgt + 0 * cur;
`endif
    endfunction

    task automatic model_reset();
        m_mode = 0; m_own = -1; m_rem = 0; m_l = 0; m_r = 0;
    endtask

    task automatic model_step();
        logic [2:0] rq;
        int tl, tr;
        bit hi;
        rq = {spi_req, rnd_req, esc_req};
        case (m_mode)
            0: if (rq != 0) begin
                m_own = first_req(rq); m_mode = 1;
            end
            1: begin
                hi = 0;
                for (int i = 0; i < m_own; i++) if (rq[i]) hi = 1;
                if (!rq[m_own] || hi) begin
                    m_mode = 2; m_own = -1; m_rem = BRK;
                end
            end
            default: if (m_l == 0 && m_r == 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_own  = first_req(rq);
                    m_mode = (m_own >= 0) ? 1 : 0;
                end
            end
        endcase
        tl = 0; tr = 0;
        case (m_own)
            0: begin tl = int'(esc_l); tr = int'(esc_r); end
            1: begin tl = int'(rnd_l); tr = int'(rnd_r); end
            2: begin tl = int'(spi_l); tr = int'(spi_r); end
            default: ;
        endcase
        m_l = move(m_l, tl);
        m_r = move(m_r, tr);
    endtask

    task automatic set_req(input logic [2:0] rq);
        {spi_req, rnd_req, esc_req} = rq;
    endtask

    initial begin
        rst = 1'b0;
        set_req(3'b000);
        esc_l = -8'sd50; esc_r = -8'sd50;
        rnd_l = 8'sd30;  rnd_r = -8'sd30;
        spi_l = 8'sd40;  spi_r = 8'sd20;
        repeat (3) @(negedge clk);
        check("reset", 3'b000, 0, 0, 1'b0, 1'b0);
        rst = 1'b1;

`ifndef SLEW_LIMIT_EN
        add(1,  3'b000, 40, 20, 3'b000,   0,   0, 0, 0);
        add(1,  3'b100, 40, 20, 3'b100,  40,  20, 1, 0);
        add(1,  3'b100, 41, -7, 3'b100,  41,  -7, 1, 0);
        add(16, 3'b101, 41, -7, 3'b000,   0,   0, 0, 1);
        add(1,  3'b101, 41, -7, 3'b001, -50, -50, 1, 0);
        add(2,  3'b011, 41, -7, 3'b001, -50, -50, 1, 0);
        add(16, 3'b010, 41, -7, 3'b000,   0,   0, 0, 1);
        add(1,  3'b010, 41, -7, 3'b010,  30, -30, 1, 0);
        add(16, 3'b000, 41, -7, 3'b000,   0,   0, 0, 1);
        add(2,  3'b000, 41, -7, 3'b000,   0,   0, 0, 0);
        add(1,  3'b001, 41, -7, 3'b001, -50, -50, 1, 0);
        add(8,  3'b000, 41, -7, 3'b000,   0,   0, 0, 1);
        add(4,  3'b010, 41, -7, 3'b000,   0,   0, 0, 1);
        add(4,  3'b000, 41, -7, 3'b000,   0,   0, 0, 1);
        add(1,  3'b000, 41, -7, 3'b000,   0,   0, 0, 0);
        add(1,  3'b010, 41, -7, 3'b010,  30, -30, 1, 0);
        add(16, 3'b001, 41, -7, 3'b000,   0,   0, 0, 1);
        add(1,  3'b001, 41, -7, 3'b001, -50, -50, 1, 0);
`else
        add(1,  3'b000, 10, 10, 3'b000,  0,  0, 0, 0);
        add(1,  3'b100, 10, 10, 3'b100,  4,  4, 1, 0);
        add(1,  3'b100, 10, 10, 3'b100,  8,  8, 1, 0);
        add(1,  3'b100, 10, 10, 3'b100, 10, 10, 1, 0);
        add(1,  3'b101, 10, 10, 3'b000,  6,  6, 0, 1);
        add(1,  3'b101, 10, 10, 3'b000,  2,  2, 0, 1);
        add(16, 3'b101, 10, 10, 3'b000,  0,  0, 0, 1);
        add(1,  3'b101, 10, 10, 3'b001, -4, -4, 1, 0);
`endif

        foreach (tbl[i]) begin
            set_req(tbl[i].req);
            spi_l = W'(tbl[i].sl);
            spi_r = W'(tbl[i].sr);
            for (int k = 0; k < tbl[i].reps; k++) begin
                @(negedge clk);
                check($sformatf("vec%0d.%0d", i, k), tbl[i].g, tbl[i].l,
                      tbl[i].r, tbl[i].me, tbl[i].br);
            end
        end

        // Release with nothing pending, then reset in the middle of brake.
        set_req(3'b000);
        repeat (5) @(negedge clk);
        n_total++;
        if (braking === 1'b1 && grant === 3'b000) n_pass++;
        else $display("FAIL mid_brake: got brk=%b grant=%b want brk=1 grant=000",
                      braking, grant);
        #2 rst = 1'b0;
        #1 check("async_rst", 3'b000, 0, 0, 1'b0, 1'b0);
        set_req(3'b001);
        @(negedge clk);
        check("rst_hold", 3'b000, 0, 0, 1'b0, 1'b0);
        set_req(3'b000);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 3'b000, 0, 0, 1'b0, 1'b0);

        model_reset();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(9) == 0) esc_req = ~esc_req;
            if ($urandom_range(7) == 0) rnd_req = ~rnd_req;
            if ($urandom_range(5) == 0) spi_req = ~spi_req;
            if ($urandom_range(5) == 0) esc_l = W'($urandom);
            if ($urandom_range(5) == 0) esc_r = W'($urandom);
            if ($urandom_range(5) == 0) rnd_l = W'($urandom);
            if ($urandom_range(5) == 0) rnd_r = W'($urandom);
            if ($urandom_range(5) == 0) spi_l = W'($urandom);
            if ($urandom_range(5) == 0) spi_r = W'($urandom);
            model_step();
            @(negedge clk);
            check($sformatf("rand%0d", c),
                  (m_own >= 0) ? 3'(1 << m_own) : 3'b000,
                  m_l, m_r, m_mode == 1, m_mode == 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
